// File: rtl/reduction_pkg.sv
// rtl/reduction_pkg.sv - shared types, constants and round-robin picker for reduction_scheduler
// Contents:
//   state_t    - scheduler FSM states (IDLE/RUN/DONE)
//   BEAT_W     - width of the per-packet beat counter
//   SAT_LIMIT  - value at which the beat counter stops counting
//   rr_pick()  - first set request bit strictly after 'last', wrapping at n
package reduction_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int BEAT_W = 8;
    localparam logic [BEAT_W-1:0] SAT_LIMIT = 8'd255;

    // Requests are zero-padded to 8 bits so one function serves every N_REQ.
    // Candidates are scanned from farthest to nearest so the nearest set bit
    // after 'last' is the one left in 'pick'.
    function automatic logic [2:0] rr_pick(input logic [7:0] valid,
                                           input int         n,
                                           input logic [2:0] last);
        logic [2:0] pick;
        int         idx;
        pick = last;
        for (int k = 8; k >= 1; k--) begin
            if (k <= n) begin
                idx = (int'(last) + k) % n;
                if (valid[3'(idx)]) begin
                    pick = 3'(idx);
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/reduction_unit.sv
// rtl/reduction_unit.sv - combinational AND/OR/XOR reduction of one data word
// Ports:
//   data     in  [W-1:0]  word to reduce
//   and_bit  out          &data
//   or_bit   out          |data
//   xor_bit  out          ^data
module reduction_unit #(
    parameter int W = 4
) (
    input  logic [W-1:0] data,
    output logic         and_bit,
    output logic         or_bit,
    output logic         xor_bit
);

    assign and_bit = &data;
    assign or_bit  = |data;
    assign xor_bit = ^data;

endmodule

// File: rtl/reduction_scheduler.sv
// rtl/reduction_scheduler.sv - round-robin owner of a shared bitwise-reduction datapath
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid/in_last       per-requester beat valid and end-of-packet
//   in_data                requester i's word at in_data[i*W +: W]
//   in_ready               per-requester accept, registered-only decode
//   grant                  one-hot current owner
//   res_valid/res_ready    result handshake
//   res_id                 owner index of the result
//   res_and/or/xor         packet reductions
//   res_beats              accepted beat count, saturating
module reduction_scheduler
    import reduction_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int W     = 4,
    localparam int ID_W = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   in_valid,
    input  logic [N_REQ*W-1:0] in_data,
    input  logic [N_REQ-1:0]   in_last,
    output logic [N_REQ-1:0]   in_ready,
    output logic [N_REQ-1:0]   grant,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [ID_W-1:0]    res_id,
    output logic               res_and,
    output logic               res_or,
    output logic               res_xor,
    output logic [BEAT_W-1:0]  res_beats
);

    state_t state, state_next;

    logic [ID_W-1:0]   owner;
    logic [ID_W-1:0]   last;
    logic [ID_W-1:0]   pick_id;
    logic [W-1:0]      owner_data;
    logic              owner_valid;
    logic              owner_last;
    logic              accept;
    logic              red_and, red_or, red_xor;
    logic              and_acc, or_acc, xor_acc;
    logic [BEAT_W-1:0] beats;
    logic [BEAT_W-1:0] beats_next;

    assign pick_id = ID_W'(rr_pick(8'(in_valid), N_REQ, 3'(last)));

    // The owner index is kept alongside the one-hot grant so the data mux
    // does not need a one-hot-to-binary encoder.
    assign owner_data  = in_data[int'(owner)*W +: W];
    assign owner_valid = in_valid[owner];
    assign owner_last  = in_last[owner];
    assign accept      = (state == RUN) && owner_valid;
    assign beats_next  = (beats == SAT_LIMIT) ? beats : beats + 1'b1;

    reduction_unit #(.W(W)) u_reduce (
        .data    (owner_data),
        .and_bit (red_and),
        .or_bit  (red_or),
        .xor_bit (red_xor)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (|in_valid)             state_next = RUN;
            RUN:     if (accept && owner_last)  state_next = DONE;
            DONE:    if (res_ready)             state_next = IDLE;
            default:                            state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = '0;
        res_valid = 1'b0;
        case (state)
            RUN:     in_ready  = grant;
            DONE:    res_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant     <= '0;
            owner     <= '0;
            last      <= ID_W'(N_REQ - 1);
            and_acc   <= 1'b1;
            or_acc    <= 1'b0;
            xor_acc   <= 1'b0;
            beats     <= '0;
            res_id    <= '0;
            res_and   <= 1'b0;
            res_or    <= 1'b0;
            res_xor   <= 1'b0;
            res_beats <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|in_valid) begin
                        grant   <= N_REQ'(1) << pick_id;
                        owner   <= pick_id;
                        last    <= pick_id;
                        and_acc <= 1'b1;
                        or_acc  <= 1'b0;
                        xor_acc <= 1'b0;
                        beats   <= '0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        and_acc <= and_acc & red_and;
                        or_acc  <= or_acc | red_or;
                        xor_acc <= xor_acc ^ red_xor;
                        beats   <= beats_next;
                        if (owner_last) begin
                            res_id    <= owner;
                            res_and   <= and_acc & red_and;
                            res_or    <= or_acc | red_or;
                            res_xor   <= xor_acc ^ red_xor;
                            res_beats <= beats_next;
                        end
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        grant <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_reduction_scheduler.sv
// tb/tb_reduction_scheduler.sv - directed vector bench for reduction_scheduler
module tb_reduction_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in_valid;
    logic [15:0] in_data;
    logic [3:0]  in_last;
    logic [3:0]  in_ready;
    logic [3:0]  grant;
    logic        res_valid;
    logic        res_ready;
    logic [1:0]  res_id;
    logic        res_and, res_or, res_xor;
    logic [7:0]  res_beats;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    reduction_scheduler #(.N_REQ(4), .W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .grant     (grant),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_and   (res_and),
        .res_or    (res_or),
        .res_xor   (res_xor),
        .res_beats (res_beats)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  vld;
        logic [15:0] data;
        logic [3:0]  lst;
        logic        rdy;
        logic [21:0] exp;
    } vec_t;

    vec_t tv[$];

    // exp packs {grant, in_ready, res_valid, res_id, and, or, xor, beats}
    function automatic vec_t mkv(input logic r, input logic [3:0] v, input logic [15:0] d,
                                 input logic [3:0] l, input logic rd,
                                 input logic [3:0] g, input logic [3:0] ir, input logic rv,
                                 input logic [1:0] id, input logic a, input logic o,
                                 input logic x, input logic [7:0] b);
        vec_t t;
        t.rst = r; t.vld = v; t.data = d; t.lst = l; t.rdy = rd;
        t.exp = {g, ir, rv, id, a, o, x, b};
        return t;
    endfunction

    function automatic logic [21:0] observed();
        return {grant, in_ready, res_valid, res_id, res_and, res_or, res_xor, res_beats};
    endfunction

    task automatic drive(input logic r, input logic [3:0] v, input logic [15:0] d,
                         input logic [3:0] l, input logic rd);
        rst = r; in_valid = v; in_data = d; in_last = l; res_ready = rd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic [21:0] held;

    initial begin
        drive(1, 0, 0, 0, 0);

        // single packet from req 2
        tv.push_back(mkv(1, 4'h0, 16'h0000, 4'h0, 0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mkv(0, 4'h4, 16'h0F00, 4'h0, 0, 4'h4, 4'h4, 0, 0, 0, 0, 0, 0));
        tv.push_back(mkv(0, 4'h4, 16'h0F00, 4'h0, 0, 4'h4, 4'h4, 0, 0, 0, 0, 0, 0));
        tv.push_back(mkv(0, 4'h4, 16'h0F00, 4'h4, 0, 4'h4, 4'h0, 1, 2, 1, 1, 0, 2));
        tv.push_back(mkv(0, 4'h0, 16'h0000, 4'h0, 1, 4'h0, 4'h0, 0, 2, 1, 1, 0, 2));
        // mixed data from req 0
        tv.push_back(mkv(0, 4'h1, 16'h0000, 4'h0, 0, 4'h1, 4'h1, 0, 2, 1, 1, 0, 2));
        tv.push_back(mkv(0, 4'h1, 16'h0000, 4'h0, 0, 4'h1, 4'h1, 0, 2, 1, 1, 0, 2));
        tv.push_back(mkv(0, 4'h1, 16'h000A, 4'h0, 0, 4'h1, 4'h1, 0, 2, 1, 1, 0, 2));
        tv.push_back(mkv(0, 4'h1, 16'h000D, 4'h1, 0, 4'h1, 4'h0, 1, 0, 0, 1, 1, 3));
        tv.push_back(mkv(0, 4'h0, 16'h0000, 4'h0, 1, 4'h0, 4'h0, 0, 0, 0, 1, 1, 3));
        // fairness: all valid, 1-beat packets of 0001
        tv.push_back(mkv(1, 4'h0, 16'h0000, 4'h0, 0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mkv(0, 4'hF, 16'h1111, 4'hF, 1, 4'h1, 4'h1, 0, 0, 0, 0, 0, 0));
        tv.push_back(mkv(0, 4'hF, 16'h1111, 4'hF, 1, 4'h1, 4'h0, 1, 0, 0, 1, 1, 1));
        tv.push_back(mkv(0, 4'hF, 16'h1111, 4'hF, 1, 4'h0, 4'h0, 0, 0, 0, 1, 1, 1));
        tv.push_back(mkv(0, 4'hF, 16'h1111, 4'hF, 1, 4'h2, 4'h2, 0, 0, 0, 1, 1, 1));
        tv.push_back(mkv(0, 4'hF, 16'h1111, 4'hF, 1, 4'h2, 4'h0, 1, 1, 0, 1, 1, 1));
        tv.push_back(mkv(0, 4'hF, 16'h1111, 4'hF, 1, 4'h0, 4'h0, 0, 1, 0, 1, 1, 1));
        tv.push_back(mkv(0, 4'hF, 16'h1111, 4'hF, 1, 4'h4, 4'h4, 0, 1, 0, 1, 1, 1));
        tv.push_back(mkv(0, 4'hF, 16'h1111, 4'hF, 1, 4'h4, 4'h0, 1, 2, 0, 1, 1, 1));
        tv.push_back(mkv(0, 4'hF, 16'h1111, 4'hF, 1, 4'h0, 4'h0, 0, 2, 0, 1, 1, 1));
        tv.push_back(mkv(0, 4'hF, 16'h1111, 4'hF, 1, 4'h8, 4'h8, 0, 2, 0, 1, 1, 1));
        tv.push_back(mkv(0, 4'hF, 16'h1111, 4'hF, 1, 4'h8, 4'h0, 1, 3, 0, 1, 1, 1));
        tv.push_back(mkv(0, 4'hF, 16'h1111, 4'hF, 1, 4'h0, 4'h0, 0, 3, 0, 1, 1, 1));
        tv.push_back(mkv(0, 4'hF, 16'h1111, 4'hF, 1, 4'h1, 4'h1, 0, 3, 0, 1, 1, 1));
        tv.push_back(mkv(0, 4'hF, 16'h1111, 4'hF, 1, 4'h1, 4'h0, 1, 0, 0, 1, 1, 1));
        tv.push_back(mkv(0, 4'h0, 16'h0000, 4'h0, 1, 4'h0, 4'h0, 0, 0, 0, 1, 1, 1));

        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].rst, tv[i].vld, tv[i].data, tv[i].lst, tv[i].rdy);
            step();
            n_vec++;
            if (observed() !== tv[i].exp) begin
                n_bad++;
                $display("FAIL vec%0d {grant,ready,rv,id,and,or,xor,beats}: got %h expected %h",
                         i, observed(), tv[i].exp);
            end
        end

        // owner stall and result backpressure (last = 0, so req 1 wins)
        drive(0, 4'h2, 16'h0030, 4'h0, 0);
        step();
        check("stall_grant", 32'(grant), 32'h2);
        step();
        drive(0, 4'h0, 16'h0000, 4'h0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_hold_grant", 32'(grant), 32'h2);
            check("stall_hold_ready", 32'(in_ready), 32'h2);
            check("stall_no_result", 32'(res_valid), 32'h0);
        end
        drive(0, 4'h2, 16'h0060, 4'h2, 0);
        step();
        check("stall_result", 32'(observed()), 32'({4'h2, 4'h0, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 8'd2}));
        held = observed();
        drive(0, 4'hD, 16'hFFFF, 4'hF, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_stable", 32'(observed()), 32'(held));
        end
        drive(0, 4'h0, 16'h0000, 4'h0, 1);
        step();
        check("bp_release_rv", 32'(res_valid), 32'h0);
        check("bp_release_grant", 32'(grant), 32'h0);

        // reset after two beats discards the packet
        drive(0, 4'h1, 16'h000F, 4'h0, 0);
        step();
        step();
        step();
        drive(1, 4'h1, 16'h000F, 4'h0, 0);
        step();
        check("reset_mid_packet", 32'(observed()), 32'h0);
        drive(0, 4'h8, 16'hF000, 4'h8, 1);
        step();
        check("post_reset_grant", 32'(grant), 32'h8);
        drive(0, 4'h8, 16'hF000, 4'h8, 0);
        step();
        check("post_reset_result", 32'(observed()), 32'({4'h8, 4'h0, 1'b1, 2'd3, 1'b1, 1'b1, 1'b0, 8'd1}));
        drive(0, 4'h0, 16'h0000, 4'h0, 1);
        step();

        // 300-beat packet saturates the beat count at 255
        drive(0, 4'h2, 16'h00F0, 4'h0, 0);
        step();
        check("sat_grant", 32'(grant), 32'h2);
        for (int i = 0; i < 299; i++) begin
            step();
        end
        check("sat_no_early_result", 32'(res_valid), 32'h0);
        drive(0, 4'h2, 16'h00F0, 4'h2, 0);
        step();
        check("sat_result", 32'(observed()), 32'({4'h2, 4'h0, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 8'd255}));
        drive(0, 4'h0, 16'h0000, 4'h0, 1);
        step();
        check("sat_release", 32'(res_valid), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
